// File: rtl/dpram_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : dpram_port_arbiter_if
// Description : Bundle of the two client handshakes, the init status flag and
//               the RAM-side signals of the dual-port RAM arbiter.
// Revision    : 1.0  initial release
// ============================================================================
interface dpram_port_arbiter_if #(
    parameter int ADDR_SIZE = 4,
    parameter int DATA_SIZE = 8
);
    // Client 0
    logic                 c0_req;
    logic                 c0_we;
    logic [ADDR_SIZE-1:0] c0_addr;
    logic [DATA_SIZE-1:0] c0_wdata;
    logic                 c0_gnt;
    logic                 c0_rvalid;
    logic [DATA_SIZE-1:0] c0_rdata;

    // Client 1
    logic                 c1_req;
    logic                 c1_we;
    logic [ADDR_SIZE-1:0] c1_addr;
    logic [DATA_SIZE-1:0] c1_wdata;
    logic                 c1_gnt;
    logic                 c1_rvalid;
    logic [DATA_SIZE-1:0] c1_rdata;

    // Status
    logic                 init_done;

    // RAM side
    logic                 ram_reset;
    logic                 ram_wr_en;
    logic [ADDR_SIZE-1:0] ram_wr_addr;
    logic [DATA_SIZE-1:0] ram_wr_data;
    logic                 ram_rd_en;
    logic [ADDR_SIZE-1:0] ram_rd_addr;
    logic [DATA_SIZE-1:0] ram_rd_data;

    // Arbiter side
    modport slave (
        input  c0_req, c0_we, c0_addr, c0_wdata,
        output c0_gnt, c0_rvalid, c0_rdata,
        input  c1_req, c1_we, c1_addr, c1_wdata,
        output c1_gnt, c1_rvalid, c1_rdata,
        output init_done,
        output ram_reset, ram_wr_en, ram_wr_addr, ram_wr_data,
        output ram_rd_en, ram_rd_addr,
        input  ram_rd_data
    );

    // Client / RAM environment side
    modport master (
        output c0_req, c0_we, c0_addr, c0_wdata,
        input  c0_gnt, c0_rvalid, c0_rdata,
        output c1_req, c1_we, c1_addr, c1_wdata,
        input  c1_gnt, c1_rvalid, c1_rdata,
        input  init_done,
        input  ram_reset, ram_wr_en, ram_wr_addr, ram_wr_data,
        input  ram_rd_en, ram_rd_addr,
        output ram_rd_data
    );
endinterface
`default_nettype wire

// File: rtl/dpram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dpram_port_arbiter
// Description : Shares one asynchronous dual-port RAM between two clients.
//               Write and read ports are arbitrated independently with a
//               round-robin pointer each. After every reset the whole RAM is
//               swept to INIT_VALUE before any client is granted.
// Revision    : 1.0  initial release
// ============================================================================
module dpram_port_arbiter #(
    parameter int                   ADDR_SIZE  = 4,
    parameter int                   DATA_SIZE  = 8,
    parameter logic [DATA_SIZE-1:0] INIT_VALUE = '0
) (
    input  wire logic          clk,
    input  wire logic          reset,
    dpram_port_arbiter_if.slave bus
);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [ADDR_SIZE-1:0] C_LAST_ADDR = {ADDR_SIZE{1'b1}};

    state_t               r_state;
    logic [ADDR_SIZE-1:0] r_cnt;
    logic                 r_wr_ptr;     // 0: C0 favoured on the write port
    logic                 r_rd_ptr;     // 0: C0 favoured on the read port
    logic                 r_c0_rvalid;
    logic                 r_c1_rvalid;
    logic [DATA_SIZE-1:0] r_c0_rdata;
    logic [DATA_SIZE-1:0] r_c1_rdata;

    logic                 w_run;
    logic                 w_sweep;
    logic                 w_c0_wreq;
    logic                 w_c0_rreq;
    logic                 w_c1_wreq;
    logic                 w_c1_rreq;
    logic                 w_c0_wgnt;
    logic                 w_c1_wgnt;
    logic                 w_c0_rgnt;
    logic                 w_c1_rgnt;
    logic                 w_wr_en;
    logic [ADDR_SIZE-1:0] w_wr_addr;
    logic [DATA_SIZE-1:0] w_wr_data;
    logic                 w_rd_en;
    logic [ADDR_SIZE-1:0] w_rd_addr;
    logic                 w_fwd;
    logic [DATA_SIZE-1:0] w_rd_value;

    // Reset overrides the state so nothing reaches the RAM while it is high
    assign w_run   = (r_state == ST_RUN)  && !reset;
    assign w_sweep = (r_state == ST_INIT) && !reset;

    // A request competes for exactly one port, chosen by its access type
    assign w_c0_wreq = bus.c0_req &&  bus.c0_we;
    assign w_c0_rreq = bus.c0_req && !bus.c0_we;
    assign w_c1_wreq = bus.c1_req &&  bus.c1_we;
    assign w_c1_rreq = bus.c1_req && !bus.c1_we;

    // Per-port round-robin: a lone competitor wins, a tie goes to the pointer
    assign w_c0_wgnt = w_run && w_c0_wreq && (!w_c1_wreq || !r_wr_ptr);
    assign w_c1_wgnt = w_run && w_c1_wreq && (!w_c0_wreq ||  r_wr_ptr);
    assign w_c0_rgnt = w_run && w_c0_rreq && (!w_c1_rreq || !r_rd_ptr);
    assign w_c1_rgnt = w_run && w_c1_rreq && (!w_c0_rreq ||  r_rd_ptr);

    // Write-port mux: init sweep, else the granted client, else all zero
    always_comb begin
        w_wr_en   = 1'b0;
        w_wr_addr = '0;
        w_wr_data = '0;
        if (w_sweep) begin
            w_wr_en   = 1'b1;
            w_wr_addr = r_cnt;
            w_wr_data = INIT_VALUE;
        end else if (w_c0_wgnt) begin
            w_wr_en   = 1'b1;
            w_wr_addr = bus.c0_addr;
            w_wr_data = bus.c0_wdata;
        end else if (w_c1_wgnt) begin
            w_wr_en   = 1'b1;
            w_wr_addr = bus.c1_addr;
            w_wr_data = bus.c1_wdata;
        end
    end

    // Read-port mux: the granted client's address, else all zero
    always_comb begin
        w_rd_en   = 1'b0;
        w_rd_addr = '0;
        if (w_c0_rgnt) begin
            w_rd_en   = 1'b1;
            w_rd_addr = bus.c0_addr;
        end else if (w_c1_rgnt) begin
            w_rd_en   = 1'b1;
            w_rd_addr = bus.c1_addr;
        end
    end

    // Write-first: a same-address write in the read cycle is forwarded so the
    // result does not depend on how the RAM resolves the collision
    assign w_fwd      = w_wr_en && w_rd_en && (w_wr_addr == w_rd_addr);
    assign w_rd_value = w_fwd ? w_wr_data : bus.ram_rd_data;

    // Controller state, sweep counter, RR pointers and read-return registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_INIT;
            r_cnt       <= '0;
            r_wr_ptr    <= 1'b0;
            r_rd_ptr    <= 1'b0;
            r_c0_rvalid <= 1'b0;
            r_c1_rvalid <= 1'b0;
            r_c0_rdata  <= '0;
            r_c1_rdata  <= '0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == C_LAST_ADDR) begin
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    // Pointer moves to the loser only when its port is used
                    if (w_c0_wgnt) begin
                        r_wr_ptr <= 1'b1;
                    end else if (w_c1_wgnt) begin
                        r_wr_ptr <= 1'b0;
                    end
                    if (w_c0_rgnt) begin
                        r_rd_ptr <= 1'b1;
                    end else if (w_c1_rgnt) begin
                        r_rd_ptr <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_INIT;
                end
            endcase

            r_c0_rvalid <= w_c0_rgnt;
            r_c1_rvalid <= w_c1_rgnt;
            if (w_c0_rgnt) begin
                r_c0_rdata <= w_rd_value;
            end
            if (w_c1_rgnt) begin
                r_c1_rdata <= w_rd_value;
            end
        end
    end

    assign bus.c0_gnt      = w_c0_wgnt || w_c0_rgnt;
    assign bus.c1_gnt      = w_c1_wgnt || w_c1_rgnt;
    // Validity is suppressed while reset is high so an aborted read never
    // shows a pulse
    assign bus.c0_rvalid   = r_c0_rvalid && !reset;
    assign bus.c1_rvalid   = r_c1_rvalid && !reset;
    assign bus.c0_rdata    = r_c0_rdata;
    assign bus.c1_rdata    = r_c1_rdata;
    assign bus.init_done   = (r_state == ST_RUN);
    assign bus.ram_reset   = reset;
    assign bus.ram_wr_en   = w_wr_en;
    assign bus.ram_wr_addr = w_wr_addr;
    assign bus.ram_wr_data = w_wr_data;
    assign bus.ram_rd_en   = w_rd_en;
    assign bus.ram_rd_addr = w_rd_addr;

endmodule
`default_nettype wire

// File: tb/tb_dpram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dpram_port_arbiter
// Description : Directed, table-driven bench for dpram_port_arbiter with a
//               behavioural asynchronous dual-port RAM attached.
// Revision    : 1.0  initial release
// ============================================================================
module tb_dpram_port_arbiter;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    dpram_port_arbiter_if #(.ADDR_SIZE(4), .DATA_SIZE(8)) bus ();

    dpram_port_arbiter #(
        .ADDR_SIZE (4),
        .DATA_SIZE (8),
        .INIT_VALUE(8'h00)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    // Behavioural RAM: reset fills it with junk so the sweep is observable
    logic [7:0] mem [16];
    always @(posedge clk) begin
        if (bus.ram_reset) begin
            for (int i = 0; i < 16; i++) mem[i] <= 8'hA5;
        end else if (bus.ram_wr_en) begin
            mem[bus.ram_wr_addr] <= bus.ram_wr_data;
        end
    end
    assign bus.ram_rd_data = mem[bus.ram_rd_addr];

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic drive(input logic q0, input logic w0, input logic [3:0] a0, input logic [7:0] d0,
                         input logic q1, input logic w1, input logic [3:0] a1, input logic [7:0] d1);
        bus.c0_req = q0; bus.c0_we = w0; bus.c0_addr = a0; bus.c0_wdata = d0;
        bus.c1_req = q1; bus.c1_we = w1; bus.c1_addr = a1; bus.c1_wdata = d1;
    endtask

    // Full 16-cycle sweep starting in the cycle after reset falls, then one
    // idle cycle in which init_done must be up
    task automatic sweep_check(input string tag);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            check($sformatf("%s sweep%0d", tag, i),
                  {bus.ram_wr_en, bus.ram_wr_addr, bus.ram_wr_data, bus.init_done,
                   bus.c0_gnt, bus.c1_gnt, bus.ram_rd_en},
                  {1'b1, i[3:0], 8'h00, 1'b0, 1'b0, 1'b0, 1'b0});
            if (i < 15) begin
                @(posedge clk); #1;
            end
        end
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check({tag, " init_done"}, {bus.init_done, bus.ram_wr_en}, {1'b1, 1'b0});
    endtask

    typedef struct {
        logic       q0, w0; logic [3:0] a0; logic [7:0] d0;
        logic       q1, w1; logic [3:0] a1; logic [7:0] d1;
        logic       g0, g1;
        logic       wen; logic [3:0] wa; logic [7:0] wd;
        logic       ren; logic [3:0] ra;
        logic       rv0; logic [7:0] rd0;
        logic       rv1; logic [7:0] rd1;
    } vec_t;

    vec_t vecs [16];

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        //          q0 w0 a0  d0     q1 w1 a1  d1     g0 g1 we wa  wd     re ra   rv0 rd0    rv1 rd1
        vecs[0]  = '{1, 1, 5, 8'h11, 1, 1, 6, 8'h22, 1, 0, 1, 5, 8'h11, 0, 0,   0, 8'h00, 0, 8'h00};
        vecs[1]  = '{1, 1, 5, 8'h11, 1, 1, 6, 8'h22, 0, 1, 1, 6, 8'h22, 0, 0,   0, 8'h00, 0, 8'h00};
        vecs[2]  = '{1, 1, 5, 8'h11, 1, 1, 6, 8'h22, 1, 0, 1, 5, 8'h11, 0, 0,   0, 8'h00, 0, 8'h00};
        vecs[3]  = '{1, 1, 5, 8'h11, 1, 1, 6, 8'h22, 0, 1, 1, 6, 8'h22, 0, 0,   0, 8'h00, 0, 8'h00};
        vecs[4]  = '{1, 0, 5, 8'h00, 1, 0, 6, 8'h00, 1, 0, 0, 0, 8'h00, 1, 5,   0, 8'h00, 0, 8'h00};
        vecs[5]  = '{1, 0, 5, 8'h00, 1, 0, 6, 8'h00, 0, 1, 0, 0, 8'h00, 1, 6,   1, 8'h11, 0, 8'h00};
        vecs[6]  = '{1, 1, 3, 8'd42, 0, 0, 0, 8'h00, 1, 0, 1, 3, 8'd42, 0, 0,   0, 8'h11, 1, 8'h22};
        vecs[7]  = '{1, 0, 3, 8'h00, 0, 0, 0, 8'h00, 1, 0, 0, 0, 8'h00, 1, 3,   0, 8'h11, 0, 8'h22};
        vecs[8]  = '{1, 1, 9, 8'd77, 1, 0, 9, 8'h00, 1, 1, 1, 9, 8'd77, 1, 9,   1, 8'd42, 0, 8'h22};
        vecs[9]  = '{0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0,   0, 8'd42, 1, 8'd77};
        vecs[10] = '{1, 0, 9, 8'h00, 1, 1, 9, 8'h55, 1, 1, 1, 9, 8'h55, 1, 9,   0, 8'd42, 0, 8'd77};
        vecs[11] = '{0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0,   1, 8'h55, 0, 8'd77};
        vecs[12] = '{1, 0,12, 8'h00, 0, 0, 0, 8'h00, 1, 0, 0, 0, 8'h00, 1,12,   0, 8'h55, 0, 8'd77};
        vecs[13] = '{0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0,   1, 8'h00, 0, 8'd77};
        vecs[14] = '{1, 1, 6, 8'h33, 1, 0, 5, 8'h00, 1, 1, 1, 6, 8'h33, 1, 5,   0, 8'h00, 0, 8'd77};
        vecs[15] = '{0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0,   0, 8'h00, 1, 8'h11};

        // Reset with a pending C0 write that must never be granted during init
        reset = 1'b1;
        drive(1, 1, 1, 8'hFF, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset outputs",
              {bus.ram_wr_en, bus.ram_rd_en, bus.ram_wr_addr, bus.ram_wr_data, bus.ram_rd_addr,
               bus.c0_gnt, bus.c1_gnt, bus.init_done, bus.ram_reset},
              {1'b0, 1'b0, 4'h0, 8'h00, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1});
        check("reset read regs",
              {bus.c0_rvalid, bus.c1_rvalid, bus.c0_rdata, bus.c1_rdata},
              {1'b0, 1'b0, 8'h00, 8'h00});
        @(posedge clk); #1;
        reset = 1'b0;
        sweep_check("first");

        // Table of post-init transactions
        for (int k = 0; k < 16; k++) begin
            @(posedge clk); #1;
            drive(vecs[k].q0, vecs[k].w0, vecs[k].a0, vecs[k].d0,
                  vecs[k].q1, vecs[k].w1, vecs[k].a1, vecs[k].d1);
            @(negedge clk);
            check($sformatf("v%0d gnt", k), {bus.c0_gnt, bus.c1_gnt}, {vecs[k].g0, vecs[k].g1});
            check($sformatf("v%0d wr", k), {bus.ram_wr_en, bus.ram_wr_addr, bus.ram_wr_data},
                  {vecs[k].wen, vecs[k].wa, vecs[k].wd});
            check($sformatf("v%0d rd", k), {bus.ram_rd_en, bus.ram_rd_addr}, {vecs[k].ren, vecs[k].ra});
            check($sformatf("v%0d c0 ret", k), {bus.c0_rvalid, bus.c0_rdata}, {vecs[k].rv0, vecs[k].rd0});
            check($sformatf("v%0d c1 ret", k), {bus.c1_rvalid, bus.c1_rdata}, {vecs[k].rv1, vecs[k].rd1});
        end

        // Reset in the middle of the sweep, at address 7
        @(posedge clk); #1;
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            check($sformatf("part sweep%0d", i), {bus.ram_wr_en, bus.ram_wr_addr}, {1'b1, i[3:0]});
            @(posedge clk); #1;
        end
        reset = 1'b1;
        @(negedge clk);
        check("mid-sweep reset", {bus.ram_wr_en, bus.ram_wr_addr, bus.ram_wr_data, bus.init_done},
              {1'b0, 4'h0, 8'h00, 1'b0});
        @(posedge clk); #1;
        reset = 1'b0;
        sweep_check("restart");

        // Reset right after a read grant
        @(posedge clk); #1;
        drive(1, 1, 3, 8'd42, 0, 0, 0, 0);
        @(negedge clk);
        check("pre-reset write gnt", {bus.c0_gnt, bus.ram_wr_en}, {1'b1, 1'b1});
        @(posedge clk); #1;
        drive(1, 0, 3, 8'h00, 0, 0, 0, 0);
        @(negedge clk);
        check("pre-reset read gnt", {bus.c0_gnt, bus.ram_rd_en, bus.ram_rd_addr}, {1'b1, 1'b1, 4'h3});
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check("aborted read", {bus.c0_rvalid, bus.c0_gnt, bus.ram_rd_en, bus.c0_rdata},
              {1'b0, 1'b0, 1'b0, 8'd42});
        @(posedge clk); #1;
        @(negedge clk);
        check("aborted read regs", {bus.c0_rvalid, bus.c0_rdata, bus.init_done}, {1'b0, 8'h00, 1'b0});
        @(posedge clk); #1;
        reset = 1'b0;
        sweep_check("post-abort");

        // Memory was swept again: the address written before reset reads 0
        @(posedge clk); #1;
        drive(1, 0, 3, 8'h00, 0, 0, 0, 0);
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("read after re-init", {bus.c0_rvalid, bus.c0_rdata}, {1'b1, 8'h00});

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
